// File: rtl/nibble_add_seq_if.sv
// ============================================================================
// Module      : nibble_add_seq_if
// Description : Operand/result handshake bundle for the nibble add sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface nibble_add_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             SUB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             OVF;

    modport master (
        output in_valid, A, B, Cin, SUB, out_ready,
        input  in_ready, out_valid, S, Cout, OVF
    );

    modport slave (
        input  in_valid, A, B, Cin, SUB, out_ready,
        output in_ready, out_valid, S, Cout, OVF
    );
endinterface

`default_nettype wire

// File: rtl/nibble_add_seq.sv
// ============================================================================
// Module      : nibble_add_seq
// Description : WIDTH-bit add/subtract, one nibble per clock through an
//               external 4-bit adder slice, carry held between cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_add_seq #(
    parameter int WIDTH = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    nibble_add_seq_if.slave  bus,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  wire logic [3:0]  add_sum,
    input  wire logic        add_cout,
    output logic             busy
);

    localparam int NIB  = WIDTH / 4;
    localparam int c_IW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [c_IW-1:0] c_LAST = c_IW'(NIB - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [c_IW-1:0]  r_idx;
    logic [c_IW+1:0]  w_base;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_last;

    assign w_base = {r_idx, 2'b00};
    assign w_last = (r_idx == c_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        busy        = 1'b0;
        add_a       = 4'd0;
        add_b       = 4'd0;
        add_cin     = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = c_RUN;
                end
            end
            c_RUN: begin
                busy    = 1'b1;
                add_a   = r_a[w_base +: 4];
                add_b   = r_b[w_base +: 4];
                add_cin = r_carry;
                if (w_last) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                busy        = 1'b1;
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // B is stored already inverted for subtraction so the RUN datapath is add-only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.A;
                        r_b     <= bus.SUB ? ~bus.B : bus.B;
                        r_carry <= bus.SUB | bus.Cin;
                        r_idx   <= '0;
                    end
                end
                c_RUN: begin
                    r_s[w_base +: 4] <= add_sum;
                    r_carry          <= add_cout;
                    r_idx            <= r_idx + c_IW'(1);
                    if (w_last) begin
                        r_cout <= add_cout;
                        r_ovf  <= (add_a[3] == add_b[3]) && (add_sum[3] != add_a[3]);
                        r_idx  <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.S         = r_s;
    assign bus.Cout      = r_cout;
    assign bus.OVF       = r_ovf;

endmodule

`default_nettype wire
